sw_pkt_tx: RTL and testbench

SW_PKT_TX -- requirements
Module: sw_pkt_tx

---
 rtl/sw_pkt_tx_if.sv | 39 +++
 rtl/sw_pkt_tx.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_sw_pkt_tx.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sw_pkt_tx_if.sv
// -----------------------------------------------------------------------------
// sw_pkt_tx_if
// Bundles the host-side write port and the switch-side byte port of sw_pkt_tx.
//   master : drives host_wr_en/host_wr_data/host_wr_last and read_out
//            (host + switch environment), observes status and frame outputs.
//   slave  : the transmitter itself.
// Signals:
//   host_wr_en, host_wr_data, host_wr_last : host byte write (DA, SA, payload)
//   host_full                               : a write now would be refused
//   pkt_err, ovf_err                        : one-cycle error pulses
//   sw_enable_in, data_in                   : frame enable and byte to switch
//   read_out                                : switch accepts current byte
//   tx_busy, tx_pkt_cnt                     : transmitter status
// -----------------------------------------------------------------------------
interface sw_pkt_tx_if #(
    parameter int WORD_WIDTH = 8
) ();
    logic                  host_wr_en;
    logic [WORD_WIDTH-1:0] host_wr_data;
    logic                  host_wr_last;
    logic                  host_full;
    logic                  pkt_err;
    logic                  ovf_err;
    logic                  sw_enable_in;
    logic [WORD_WIDTH-1:0] data_in;
    logic                  read_out;
    logic                  tx_busy;
    logic [15:0]           tx_pkt_cnt;

    modport master (
        output host_wr_en, host_wr_data, host_wr_last, read_out,
        input  host_full, pkt_err, ovf_err, sw_enable_in, data_in, tx_busy, tx_pkt_cnt
    );

    modport slave (
        input  host_wr_en, host_wr_data, host_wr_last, read_out,
        output host_full, pkt_err, ovf_err, sw_enable_in, data_in, tx_busy, tx_pkt_cnt
    );
endinterface

// File: rtl/sw_pkt_tx.sv
// -----------------------------------------------------------------------------
// sw_pkt_tx
// Buffers host packets (DA, SA, payload) and sends them to a switch as
// DA, SA, LEN, payload [, PAR] frames, LEN being the payload byte count.
// Host bytes land at a speculative pointer; only a well-formed final byte
// commits the packet (commit pointer + length-queue push). A final byte on DA
// or SA discards the partial packet.
// Ports:
//   clk   : single rising-edge clock
//   rst_n : synchronous active-low reset, clears everything incl. mid-frame
//   bus   : sw_pkt_tx_if.slave (host write port, switch port, status)
// Parameters: FIFO_SIZE (byte buffer depth, power of 2, 8..256),
//   WORD_WIDTH (8), LQ_DEPTH (length-queue entries, power of 2, >= 2).
// Build option: define SW_PKT_TX_PARITY_EN to append an XOR parity byte
//   (DA ^ SA ^ LEN ^ payload) after the last payload byte.
// -----------------------------------------------------------------------------
module sw_pkt_tx #(
    parameter int FIFO_SIZE  = 64,
    parameter int WORD_WIDTH = 8,
    parameter int LQ_DEPTH   = 8
) (
    input logic        clk,
    input logic        rst_n,
    sw_pkt_tx_if.slave bus
);
    localparam int AW = $clog2(FIFO_SIZE);
    localparam int PW = AW + 1;                       // extra bit tells full from empty
    localparam int QW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
    localparam int CW = QW + 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DA   = 3'd1,
        ST_SA   = 3'd2,
        ST_LEN  = 3'd3,
        ST_PAY  = 3'd4,
`ifdef SW_PKT_TX_PARITY_EN
        ST_PAR  = 3'd5,
`endif
        ST_GAP  = 3'd6
    } state_t;

`ifdef SW_PKT_TX_PARITY_EN
    function automatic logic [WORD_WIDTH-1:0] par_fold(
        input logic [WORD_WIDTH-1:0] acc,
        input logic [WORD_WIDTH-1:0] b
    );
        return acc ^ b;
    endfunction
`endif

    // Storage
    logic [WORD_WIDTH-1:0] mem_r [FIFO_SIZE];
    logic [WORD_WIDTH-1:0] lq_r  [LQ_DEPTH];

    // Pointers and counters
    logic [PW-1:0]         spec_ptr_r, commit_ptr_r, rd_ptr_r, wr_cnt_r;
    logic [PW-1:0]         spec_nxt_s, commit_nxt_s, rd_nxt_s, wr_cnt_nxt_s;
    logic [QW-1:0]         lq_wr_r, lq_rd_r;
    logic [CW-1:0]         lq_cnt_r, lq_cnt_nxt_s;
    logic [WORD_WIDTH-1:0] pay_left_r, pay_left_nxt_s;
    logic [WORD_WIDTH-1:0] len_push_s;
    logic                  wr_acc_s, push_s, pop_s, bad_last_s, xfer_s, full_nxt_s;

    // FSM
    state_t                state_r, state_nxt_s;

    // Registered outputs and their next values
    logic                  host_full_r, pkt_err_r, ovf_err_r, sw_en_r, busy_r;
    logic [WORD_WIDTH-1:0] data_r, data_nxt_s;
    logic                  sw_en_nxt_s, busy_nxt_s;
    logic [15:0]           cnt_r;

`ifdef SW_PKT_TX_PARITY_EN
    logic [WORD_WIDTH-1:0] par_r, par_nxt_s;
`endif

    assign xfer_s = sw_en_r & bus.read_out;

    // Host side: accept bytes, advance/rewind speculative pointer, commit packets
    always_comb begin
        wr_acc_s     = bus.host_wr_en & ~host_full_r;
        spec_nxt_s   = spec_ptr_r;
        commit_nxt_s = commit_ptr_r;
        wr_cnt_nxt_s = wr_cnt_r;
        push_s       = 1'b0;
        bad_last_s   = 1'b0;
        // wr_cnt_r counts DA+SA+earlier payload, so payload incl. this byte = wr_cnt_r - 1
        len_push_s   = WORD_WIDTH'(wr_cnt_r - PW'(1));
        if (wr_acc_s) begin
            if (bus.host_wr_last && (wr_cnt_r < PW'(2))) begin
                spec_nxt_s   = commit_ptr_r;
                wr_cnt_nxt_s = {PW{1'b0}};
                bad_last_s   = 1'b1;
            end else if (bus.host_wr_last) begin
                spec_nxt_s   = spec_ptr_r + PW'(1);
                commit_nxt_s = spec_ptr_r + PW'(1);
                wr_cnt_nxt_s = {PW{1'b0}};
                push_s       = 1'b1;
            end else begin
                spec_nxt_s   = spec_ptr_r + PW'(1);
                wr_cnt_nxt_s = wr_cnt_r + PW'(1);
            end
        end else begin
            push_s = 1'b0;
        end
    end

    // FSM next state plus read-pointer / payload-counter advance on transfers
    always_comb begin
        state_nxt_s    = state_r;
        rd_nxt_s       = rd_ptr_r;
        pay_left_nxt_s = pay_left_r;
        pop_s          = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (lq_cnt_r != CW'(0)) state_nxt_s = ST_DA;
                else                    state_nxt_s = ST_IDLE;
            end
            ST_DA: begin
                if (xfer_s) begin
                    state_nxt_s = ST_SA;
                    rd_nxt_s    = rd_ptr_r + PW'(1);
                end else begin
                    state_nxt_s = ST_DA;
                end
            end
            ST_SA: begin
                if (xfer_s) begin
                    state_nxt_s = ST_LEN;
                    rd_nxt_s    = rd_ptr_r + PW'(1);
                end else begin
                    state_nxt_s = ST_SA;
                end
            end
            ST_LEN: begin
                if (xfer_s) begin
                    state_nxt_s    = ST_PAY;
                    pay_left_nxt_s = lq_r[lq_rd_r];
                end else begin
                    state_nxt_s = ST_LEN;
                end
            end
            ST_PAY: begin
                if (xfer_s) begin
                    rd_nxt_s       = rd_ptr_r + PW'(1);
                    pay_left_nxt_s = pay_left_r - WORD_WIDTH'(1);
                    if (pay_left_r == WORD_WIDTH'(1)) begin
`ifdef SW_PKT_TX_PARITY_EN
                        state_nxt_s = ST_PAR;
`else
                        state_nxt_s = ST_GAP;
                        pop_s       = 1'b1;
`endif
                    end else begin
                        state_nxt_s = ST_PAY;
                    end
                end else begin
                    state_nxt_s = ST_PAY;
                end
            end
`ifdef SW_PKT_TX_PARITY_EN
            ST_PAR: begin
                if (xfer_s) begin
                    state_nxt_s = ST_GAP;
                    pop_s       = 1'b1;
                end else begin
                    state_nxt_s = ST_PAR;
                end
            end
`endif
            ST_GAP: begin
                // queue count already reflects the pop of the packet just sent
                if (lq_cnt_r != CW'(0)) state_nxt_s = ST_DA;
                else                    state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

`ifdef SW_PKT_TX_PARITY_EN
    // Running XOR of every byte sent in the current frame before PAR
    always_comb begin
        par_nxt_s = par_r;
        if (xfer_s) begin
            case (state_r)
                ST_DA:                  par_nxt_s = data_r;
                ST_SA, ST_LEN, ST_PAY:  par_nxt_s = par_fold(par_r, data_r);
                default:                par_nxt_s = par_r;
            endcase
        end else begin
            par_nxt_s = par_r;
        end
    end
`endif

    // Queue occupancy and full flag as they will be after this edge
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   lq_cnt_nxt_s = lq_cnt_r + CW'(1);
            2'b01:   lq_cnt_nxt_s = lq_cnt_r - CW'(1);
            default: lq_cnt_nxt_s = lq_cnt_r;
        endcase
        full_nxt_s = ((spec_nxt_s - rd_nxt_s) == PW'(FIFO_SIZE)) ||
                     (lq_cnt_nxt_s == CW'(LQ_DEPTH));
    end

    // Output decode from the next state so registered outputs line up with it
    always_comb begin
        sw_en_nxt_s = 1'b0;
        data_nxt_s  = {WORD_WIDTH{1'b0}};
        busy_nxt_s  = (state_nxt_s != ST_IDLE);
        case (state_nxt_s)
            ST_DA, ST_SA, ST_PAY: begin
                sw_en_nxt_s = 1'b1;
                data_nxt_s  = mem_r[rd_nxt_s[AW-1:0]];
            end
            ST_LEN: begin
                sw_en_nxt_s = 1'b1;
                data_nxt_s  = lq_r[lq_rd_r];
            end
`ifdef SW_PKT_TX_PARITY_EN
            ST_PAR: begin
                sw_en_nxt_s = 1'b1;
                data_nxt_s  = par_nxt_s;
            end
`endif
            default: begin
                sw_en_nxt_s = 1'b0;
                data_nxt_s  = {WORD_WIDTH{1'b0}};
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state_r <= ST_IDLE;
        else        state_r <= state_nxt_s;
    end

    // Byte buffer write port (contents need no reset; pointers gate validity)
    always_ff @(posedge clk) begin
        if (wr_acc_s) mem_r[spec_ptr_r[AW-1:0]] <= bus.host_wr_data;
    end

    // Length-queue write port
    always_ff @(posedge clk) begin
        if (push_s) lq_r[lq_wr_r] <= len_push_s;
    end

    // Pointer, counter and queue-index registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            spec_ptr_r   <= {PW{1'b0}};
            commit_ptr_r <= {PW{1'b0}};
            rd_ptr_r     <= {PW{1'b0}};
            wr_cnt_r     <= {PW{1'b0}};
            lq_wr_r      <= {QW{1'b0}};
            lq_rd_r      <= {QW{1'b0}};
            lq_cnt_r     <= {CW{1'b0}};
            pay_left_r   <= {WORD_WIDTH{1'b0}};
        end else begin
            spec_ptr_r   <= spec_nxt_s;
            commit_ptr_r <= commit_nxt_s;
            rd_ptr_r     <= rd_nxt_s;
            wr_cnt_r     <= wr_cnt_nxt_s;
            lq_wr_r      <= push_s ? lq_wr_r + QW'(1) : lq_wr_r;
            lq_rd_r      <= pop_s  ? lq_rd_r + QW'(1) : lq_rd_r;
            lq_cnt_r     <= lq_cnt_nxt_s;
            pay_left_r   <= pay_left_nxt_s;
        end
    end

`ifdef SW_PKT_TX_PARITY_EN
    // Parity accumulator register
    always_ff @(posedge clk) begin
        if (!rst_n) par_r <= {WORD_WIDTH{1'b0}};
        else        par_r <= par_nxt_s;
    end
`endif

    // Registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            host_full_r <= 1'b0;
            pkt_err_r   <= 1'b0;
            ovf_err_r   <= 1'b0;
            sw_en_r     <= 1'b0;
            data_r      <= {WORD_WIDTH{1'b0}};
            busy_r      <= 1'b0;
            cnt_r       <= 16'd0;
        end else begin
            host_full_r <= full_nxt_s;
            pkt_err_r   <= bad_last_s;
            ovf_err_r   <= bus.host_wr_en & host_full_r;
            sw_en_r     <= sw_en_nxt_s;
            data_r      <= data_nxt_s;
            busy_r      <= busy_nxt_s;
            cnt_r       <= pop_s ? cnt_r + 16'd1 : cnt_r;
        end
    end

    assign bus.host_full    = host_full_r;
    assign bus.pkt_err      = pkt_err_r;
    assign bus.ovf_err      = ovf_err_r;
    assign bus.sw_enable_in = sw_en_r;
    assign bus.data_in      = data_r;
    assign bus.tx_busy      = busy_r;
    assign bus.tx_pkt_cnt   = cnt_r;
endmodule

// File: tb/tb_sw_pkt_tx.sv
// Self-checking bench for sw_pkt_tx: directed scenarios plus randomized traffic
// against a packet-level reference model (expected byte stream queue,
// buffer occupancy and queued-packet count).
module tb_sw_pkt_tx;
    localparam int FIFO_SIZE  = 64;
    localparam int WORD_WIDTH = 8;
    localparam int LQ_DEPTH   = 8;

    typedef struct packed { logic [7:0] val; logic from_buf; logic last; } xb_t;
    typedef struct packed { logic [7:0] data; logic last; } hb_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    xb_t        exp_q[$];     // bytes the switch must still see, in order
    logic [7:0] cur_q[$];     // accepted bytes of the packet being written
    hb_t        host_q[$];    // bytes the host still wants to write
    logic [7:0] tx_log[$];    // bytes actually transferred
    int         committed_occ = 0;
    int         lq_n          = 0;
    logic [15:0] pkt_cnt      = 16'd0;
    bit         accepted      = 1'b0;
    bit         toggle_rd     = 1'b0;
    int         ovf_seen      = 0;
    int         perr_seen     = 0;

    sw_pkt_tx_if #(.WORD_WIDTH(WORD_WIDTH)) bus ();

    sw_pkt_tx #(
        .FIFO_SIZE (FIFO_SIZE),
        .WORD_WIDTH(WORD_WIDTH),
        .LQ_DEPTH  (LQ_DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_full();
        return ((committed_occ + cur_q.size()) >= FIFO_SIZE) || (lq_n >= LQ_DEPTH);
    endfunction

    function automatic xb_t mk(input logic [7:0] v, input logic b);
        xb_t e;
        e.val = v; e.from_buf = b; e.last = 1'b0;
        return e;
    endfunction

    // Turn the accepted host packet into its switch-side frame
    task automatic commit_pkt();
        xb_t fr[$];
        xb_t e;
        logic [7:0] par;
        int n;
        n = cur_q.size();
        fr.push_back(mk(cur_q[0], 1'b1));
        fr.push_back(mk(cur_q[1], 1'b1));
        fr.push_back(mk(8'(n - 2), 1'b0));
        for (int i = 2; i < n; i++) fr.push_back(mk(cur_q[i], 1'b1));
`ifdef SW_PKT_TX_PARITY_EN
        par = 8'h00;
        for (int i = 0; i < fr.size(); i++) par = par ^ fr[i].val;
        fr.push_back(mk(par, 1'b0));
`else
        par = 8'h00;
`endif
        for (int i = 0; i < fr.size(); i++) begin
            e = fr[i];
            e.last = (i == fr.size() - 1);
            exp_q.push_back(e);
        end
        committed_occ += n;
        lq_n++;
        cur_q.delete();
    endtask

    // One clock: apply current inputs, advance the model, check outputs after the edge
    task automatic tick();
        bit o_en, i_wr, i_last, i_rd, i_rst, full_before, q_before, xfer, xfer_last, exp_en;
        bit exp_perr, exp_ovf;
        logic [7:0] o_data, i_data;
        xb_t xb;
        o_en   = bus.sw_enable_in;
        o_data = bus.data_in;
        i_wr   = bus.host_wr_en;
        i_data = bus.host_wr_data;
        i_last = bus.host_wr_last;
        i_rd   = bus.read_out;
        i_rst  = !rst_n;
        full_before = model_full();
        q_before    = (exp_q.size() != 0);
        @(posedge clk);
        #1;
        accepted = 1'b0;
        if (bus.ovf_err === 1'b1) ovf_seen++;
        if (bus.pkt_err === 1'b1) perr_seen++;
        if (i_rst) begin
            exp_q.delete(); cur_q.delete();
            committed_occ = 0; lq_n = 0; pkt_cnt = 16'd0;
            check_val("rst_en",   bus.sw_enable_in, 0);
            check_val("rst_data", bus.data_in, 0);
            check_val("rst_cnt",  bus.tx_pkt_cnt, 0);
            check_val("rst_full", bus.host_full, 0);
            check_val("rst_busy", bus.tx_busy, 0);
            check_val("rst_errs", {bus.pkt_err, bus.ovf_err}, 0);
            return;
        end
        exp_perr = 1'b0; exp_ovf = 1'b0; xfer_last = 1'b0;
        xfer = o_en && i_rd;
        if (xfer) begin
            tx_log.push_back(o_data);
            if (exp_q.size() == 0) begin
                check_val("xfer_unexpected", 1, 0);
            end else begin
                xb = exp_q.pop_front();
                check_val("xfer_data", o_data, xb.val);
                if (xb.from_buf) committed_occ--;
                if (xb.last) begin
                    xfer_last = 1'b1; lq_n--; pkt_cnt = pkt_cnt + 16'd1;
                end
            end
        end
        if (i_wr) begin
            if (full_before) begin
                exp_ovf = 1'b1;
            end else begin
                accepted = 1'b1;
                cur_q.push_back(i_data);
                if (i_last) begin
                    if (cur_q.size() < 3) begin
                        exp_perr = 1'b1;
                        cur_q.delete();
                    end else begin
                        commit_pkt();
                    end
                end
            end
        end
        if (xfer)      exp_en = !xfer_last;
        else if (o_en) exp_en = 1'b1;
        else           exp_en = q_before;
        check_val("sw_enable_in", bus.sw_enable_in, exp_en);
        if (exp_en && exp_q.size() != 0) check_val("data_in", bus.data_in, exp_q[0].val);
        else if (exp_en)                 check_val("frame_without_pkt", 1, 0);
        else                             check_val("data_idle_zero", bus.data_in, 0);
        check_val("tx_busy",    bus.tx_busy, exp_en || xfer_last);
        check_val("pkt_err",    bus.pkt_err, exp_perr);
        check_val("ovf_err",    bus.ovf_err, exp_ovf);
        check_val("tx_pkt_cnt", bus.tx_pkt_cnt, pkt_cnt);
        check_val("host_full",  bus.host_full, model_full());
    endtask

    task automatic run_cycles(input int n, input int rd_pct, input int wr_pct, input int force_pct);
        for (int c = 0; c < n; c++) begin
            if (toggle_rd) bus.read_out = (c % 2 == 0);
            else           bus.read_out = (int'($urandom_range(99)) < rd_pct);
            if (host_q.size() != 0 && int'($urandom_range(99)) < wr_pct &&
                (!model_full() || int'($urandom_range(99)) < force_pct)) begin
                bus.host_wr_en   = 1'b1;
                bus.host_wr_data = host_q[0].data;
                bus.host_wr_last = host_q[0].last;
            end else begin
                bus.host_wr_en   = 1'b0;
                bus.host_wr_data = 8'($urandom);
                bus.host_wr_last = 1'b0;
            end
            tick();
            if (accepted) void'(host_q.pop_front());
        end
        bus.host_wr_en = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget, input int rd_pct, input int force_pct);
        int b;
        b = budget;
        while ((host_q.size() != 0 || exp_q.size() != 0) && b > 0) begin
            run_cycles(1, rd_pct, 100, force_pct);
            b--;
        end
        check_val({tag, "_drain_left"}, host_q.size() + exp_q.size(), 0);
        run_cycles(2, 100, 100, 0);
    endtask

    task automatic queue_host(input logic [7:0] d, input logic l);
        hb_t h;
        h.data = d; h.last = l;
        host_q.push_back(h);
    endtask

    // bad_at: 0 well-formed, 1 last on DA, 2 last on SA
    task automatic queue_pkt(input int n_pay, input int bad_at);
        queue_host(8'($urandom), bad_at == 1);
        if (bad_at == 1) return;
        queue_host(8'($urandom), bad_at == 2);
        if (bad_at == 2) return;
        for (int i = 0; i < n_pay; i++) queue_host(8'($urandom), i == n_pay - 1);
    endtask

    task automatic queue_ref_pkt();
        queue_host(8'h01, 1'b0);
        queue_host(8'h10, 1'b0);
        queue_host(8'hAA, 1'b0);
        queue_host(8'hBB, 1'b1);
    endtask

    // Transmitted bytes must be exactly the reference frame (constants only)
    task automatic check_ref_log(input string tag);
        logic [7:0] ref_b[$];
        ref_b.push_back(8'h01); ref_b.push_back(8'h10); ref_b.push_back(8'h02);
        ref_b.push_back(8'hAA); ref_b.push_back(8'hBB);
`ifdef SW_PKT_TX_PARITY_EN
        ref_b.push_back(8'h02);
`endif
        check_val({tag, "_len"}, tx_log.size(), ref_b.size());
        for (int i = 0; i < ref_b.size() && i < tx_log.size(); i++)
            check_val({tag, "_byte"}, tx_log[i], ref_b[i]);
    endtask

    initial begin
        int b;
        bus.host_wr_en = 1'b0; bus.host_wr_data = 8'h00; bus.host_wr_last = 1'b0;
        bus.read_out   = 1'b0;

        // Reset and release
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check_val("post_reset_full", bus.host_full, 0);

        // Reference packet, switch always ready
        tx_log.delete();
        queue_ref_pkt();
        run_cycles(14, 100, 100, 0);
        check_ref_log("ref_pkt");
        check_val("ref_pkt_cnt", bus.tx_pkt_cnt, 1);

        // Same packet, read_out toggling
        tx_log.delete();
        toggle_rd = 1'b1;
        queue_ref_pkt();
        run_cycles(30, 100, 100, 0);
        toggle_rd = 1'b0;
        check_ref_log("toggle_pkt");
        check_val("toggle_pkt_cnt", bus.tx_pkt_cnt, 2);

        // Final byte on SA discarded, following packet intact
        tx_log.delete();
        perr_seen = 0;
        queue_host(8'h33, 1'b0);
        queue_host(8'h44, 1'b1);
        queue_ref_pkt();
        run_cycles(20, 100, 100, 0);
        check_ref_log("bad_sa_pkt");
        check_val("bad_sa_perr_seen", perr_seen, 1);
        check_val("bad_sa_cnt", bus.tx_pkt_cnt, 3);

        // Length queue fills with switch stalled, then overflow writes
        ovf_seen = 0;
        for (int k = 0; k < LQ_DEPTH + 1; k++) queue_pkt(1, 0);
        run_cycles(40, 0, 100, 100);
        check_val("lq_full_ovf_seen", ovf_seen != 0, 1);
        drain("lq_full", 400, 100, 0);

        // Byte buffer fills with switch stalled
        ovf_seen = 0;
        for (int k = 0; k < 4; k++) queue_pkt(20, 0);
        run_cycles(100, 0, 100, 100);
        check_val("buf_full_flag", bus.host_full, 1);
        check_val("buf_full_ovf_seen", ovf_seen != 0, 1);
        drain("buf_full", 600, 100, 0);

        // Reset in the middle of a payload
        tx_log.delete();
        queue_pkt(10, 0);
        b = 40;
        while (tx_log.size() < 4 && b > 0) begin
            run_cycles(1, 100, 100, 0);
            b--;
        end
        check_val("midframe_reached_pay", tx_log.size() >= 4, 1);
        host_q.delete();
        bus.host_wr_en = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check_val("midframe_full_after", bus.host_full, 0);
        check_val("midframe_cnt_after", bus.tx_pkt_cnt, 0);
        queue_pkt(5, 0);
        drain("after_reset", 200, 100, 0);

        // Randomized traffic
        for (int grp = 0; grp < 15; grp++) begin
            for (int k = 0; k < 20; k++) begin
                if ($urandom_range(9) == 0) queue_pkt(0, 1 + int'($urandom_range(1)));
                else                        queue_pkt(1 + int'($urandom_range(19)), 0);
            end
            drain("random", 6000, 25 + int'($urandom_range(75)), 20);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
